// File: rtl/piso_tx_controller_pkg.sv
// rtl/piso_tx_controller_pkg.sv - shared state encoding and counter sizing for the PISO sequencer
package piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Bits needed to count 0..n-1, never less than one bit
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_tx_controller_if.sv
// rtl/piso_tx_controller_if.sv - parallel word handshake and framed serial output bundle
interface piso_tx_controller_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sout_valid;
    logic             frame_start;
    logic             frame_end;

    modport master (
        output din, din_valid,
        input  din_ready, sout, sout_valid, frame_start, frame_end
    );

    modport slave (
        input  din, din_valid,
        output din_ready, sout, sout_valid, frame_start, frame_end
    );
endinterface

// File: rtl/piso_shift_core.sv
// rtl/piso_shift_core.sv - loadable shift register presenting one serial bit
module piso_shift_core #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q
);
    logic [WIDTH-1:0] sr;

    // Load wins over shift so a back-to-back word replaces the drained register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= d;
        end else if (shift) begin
            if (MSB_FIRST != 0) begin
                sr <= {sr[WIDTH-2:0], 1'b0};
            end else begin
                sr <= {1'b0, sr[WIDTH-1:1]};
            end
        end
    end

    assign q = (MSB_FIRST != 0) ? sr[WIDTH-1] : sr[0];
endmodule

// File: rtl/piso_tx_controller.sv
// rtl/piso_tx_controller.sv - handshake, framing and gap sequencing around the shift core
module piso_tx_controller
    import piso_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int MSB_FIRST  = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    piso_tx_controller_if.slave  bus,
    output logic                 busy
);
    localparam int BW = cnt_width(WIDTH);
    localparam int GW = cnt_width(GAP_CYCLES + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t        state;
    logic [BW-1:0] bit_cnt;
    logic [GW-1:0] gap_cnt;
    logic          last_bit;
    logic          accept;
    logic          core_q;

    assign last_bit      = (state == ST_SHIFT) && (bit_cnt == BIT_LAST);
    // Ready on the final bit only when no gap is owed, giving gapless streaming
    assign bus.din_ready = !Rst && ((state == ST_IDLE) || (last_bit && (GAP_CYCLES == 0)));
    assign accept        = bus.din_valid && bus.din_ready;

    piso_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .Clk   (Clk),
        .Rst   (Rst),
        .load  (accept),
        .shift (state == ST_SHIFT),
        .d     (bus.din),
        .q     (core_q)
    );

    // Frame sequencing: idle -> shift WIDTH bits -> optional gap -> idle
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (accept) begin
                            state <= ST_SHIFT;
                        end else if (GAP_CYCLES > 0) begin
                            state   <= ST_GAP;
                            gap_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state   <= ST_IDLE;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
                    gap_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.sout_valid  = (state == ST_SHIFT);
    assign bus.sout        = core_q && (state == ST_SHIFT);
    assign bus.frame_start = (state == ST_SHIFT) && (bit_cnt == '0);
    assign bus.frame_end   = last_bit;
    assign busy            = (state != ST_IDLE);
endmodule

// File: doc/piso_tx_controller.md
Name: piso_tx_controller

Overview:
- Sequencer for a parallel-in/serial-out shift register.
- Accepts parallel words from an upstream producer over a valid/ready handshake and drives the load/shift control of the shift core.
- Emits the serial bitstream with a per-bit valid and start/end-of-frame markers.
- Sits between a parallel data source and any serial sink (UART-like framer, SPI MOSI stage, LED driver).

Parameters:
- WIDTH, 4: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- GAP_CYCLES, 0: idle cycles forced between consecutive frames; legal range 0..15.

Ports:
- Clk  input  1  system clock; all logic on the rising edge.
- Rst  input  1  reset, synchronous, active-high.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  controller can accept a word this cycle.
- sout  output  1  serial data bit (registered).
- sout_valid  output  1  sout carries a frame bit this cycle.
- frame_start  output  1  high during the first bit of a frame.
- frame_end  output  1  high during the last bit of a frame.
- busy  output  1  high while in SHIFT or GAP.

Behaviour:
- Reset: one clock is synchronous and reset is synchronous, active-high.
  - While Rst is high at a rising edge: state becomes IDLE; bit counter and gap counter become 0; shift register becomes 0.
  - Outputs after that edge: sout=0, sout_valid=0, frame_start=0, frame_end=0, busy=0.
  - din_ready is forced to 0 during any cycle in which Rst is high.
- States: IDLE, SHIFT, GAP. Encoding comes from the package.
- Accept: a word is accepted at a rising edge where din_valid && din_ready.
  - On accept, the shift core loads din and bit_cnt is cleared to 0.
  - din is sampled only at the accept edge; later changes to din are ignored.
- din_ready is high in either case:
  - (state==IDLE && !Rst), or
  - (state==SHIFT && bit_cnt==WIDTH-1 && GAP_CYCLES==0 && !Rst). This case gives back-to-back frames.
- IDLE:
  - sout_valid=0, sout=0.
  - On accept, go to SHIFT.
- SHIFT:
  - sout_valid=1, and sout = the current output bit of the shift core (MSB or LSB per MSB_FIRST).
  - Each edge shifts the core by one position, filling with 0, and increments bit_cnt.
  - frame_start = (bit_cnt==0); frame_end = (bit_cnt==WIDTH-1).
- Exit from SHIFT at the edge where bit_cnt==WIDTH-1:
  - Accept at that edge: reload and stay in SHIFT with bit_cnt=0. No bubble; sout_valid stays high.
  - Else if GAP_CYCLES>0: go to GAP with gap_cnt=0.
  - Else: go to IDLE.
- GAP:
  - sout_valid=0, din_ready=0.
  - gap_cnt increments each cycle; at gap_cnt==GAP_CYCLES-1, go to IDLE.
- Latency: accept at edge k puts the first bit on sout in the cycle after edge k. A frame occupies exactly WIDTH consecutive cycles.
- Throughput: with GAP_CYCLES=0, one bit per clock sustained. Otherwise the period is WIDTH+GAP_CYCLES+1 cycles per word, because IDLE lasts at least one cycle after GAP.
- din_valid while not ready: no effect. The producer must hold the word, and it is accepted at the first ready edge.
- Reset mid-frame: the frame is aborted, with no frame_end and no further bits. The next accepted word starts a fresh frame.
- Counter widths:
  - bit_cnt uses max(1,$clog2(WIDTH)) bits and never exceeds WIDTH-1.
  - gap_cnt uses max(1,$clog2(GAP_CYCLES+1)) bits.

Decomposition:
- Package piso_pkg:
  - state typedef/localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_GAP=2'd2.
  - counter-width helper function.
- Sub-module piso_shift_core, parameters WIDTH and MSB_FIRST:
  - ports Clk, Rst, load, shift, d[WIDTH-1:0], q.
  - load has priority over shift; q is the registered output bit.
- The controller holds the FSM, counters, handshake logic and framing flags.

Test Plan:
- Single frame: WIDTH=4, MSB_FIRST=1, GAP_CYCLES=0, din=4'b1011 accepted at edge 0. Required: sout=1,0,1,1 in cycles 1-4, sout_valid high only in cycles 1-4, frame_start in cycle 1, frame_end in cycle 4, din_ready low in cycles 1-3.
- Back-to-back: 4'b1011 then 4'b0110 with din_valid held. Required: 8 contiguous valid bits 1,0,1,1,0,1,1,0; sout_valid never drops; second accept occurs in cycle 4 (din_ready high there).
- Gap: GAP_CYCLES=2, two words queued. Required: 4 bits, then 3 cycles with sout_valid=0 (2 GAP + 1 IDLE), then the next 4 bits; din_ready=0 throughout GAP.
- LSB first: MSB_FIRST=0, din=4'b1011. Required: sout=1,1,0,1.
- Reset mid-frame: Rst high during the cycle carrying bit 2 of 4'b1011. Required: next cycle has sout_valid=0, sout=0, busy=0 and no frame_end. Then din=4'b0001 sends 0,0,0,1 with frame_start on its first bit.
- Stall: din_valid asserted during SHIFT, word changing between 4'b1111 and 4'b0000 while not ready. Required: no accept until din_ready, and the value present at the accept edge is the one serialized.
